// File: rtl/led_pulse_driver.sv
// Blinks an LED a fixed number of times after each trigger pulse.
// Define LED_PULSE_DRIVER_RETRIGGER_EN to let a pulse while busy restart the sequence.
module led_pulse_driver #(
  parameter int unsigned ON_CYCLES  = 4,
  parameter int unsigned OFF_CYCLES = 2,
  parameter int unsigned BLINKS     = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pulse_in,
  output logic led_out,
  output logic busy,
  output logic done
);

  localparam int unsigned PhaseMax = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned PhaseW   = $clog2(PhaseMax + 1);
  localparam int unsigned BlinkW   = $clog2(BLINKS + 1);

`ifdef LED_PULSE_DRIVER_RETRIGGER_EN
  localparam bit Retrigger = 1'b1;
`else
  localparam bit Retrigger = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StOn, StOff} state_e;

  state_e              state_q, state_d;
  logic [PhaseW-1:0]   phase_q, phase_d;
  logic [BlinkW-1:0]   blink_q, blink_d;
  logic                led_q, led_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                start;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    blink_d = blink_q;
    done_d  = 1'b0;
    start   = pulse_in && ((state_q == StIdle) || Retrigger);

    unique case (state_q)
      StIdle: ;
      StOn: begin
        if (phase_q == PhaseW'(1)) begin
          if (blink_q > BlinkW'(1)) begin
            state_d = StOff;
            phase_d = PhaseW'(OFF_CYCLES);
            blink_d = blink_q - BlinkW'(1);
          end else begin
            state_d = StIdle;
            phase_d = '0;
            blink_d = '0;
            done_d  = 1'b1;
          end
        end else begin
          phase_d = phase_q - PhaseW'(1);
        end
      end
      StOff: begin
        if (phase_q == PhaseW'(1)) begin
          state_d = StOn;
          phase_d = PhaseW'(ON_CYCLES);
        end else begin
          phase_d = phase_q - PhaseW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        phase_d = '0;
        blink_d = '0;
      end
    endcase

    // A trigger (or retrigger) overrides completion, so an aborted run never pulses done.
    if (start) begin
      state_d = StOn;
      phase_d = PhaseW'(ON_CYCLES);
      blink_d = BlinkW'(BLINKS);
      done_d  = 1'b0;
    end

    led_d  = (state_d == StOn);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      phase_q <= '0;
      blink_q <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      blink_q <= blink_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign led_out = led_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
